alu_arbiter: RTL and testbench

Shares one combinational integer ALU between two requesters, for example the execute stage and the branch/address unit. It uses round-robin arbitration and valid/ready handshakes. The selected operation is computed in the accept cycle and registered into a single-entry response buffer tagged with the requester ID. It sits between the decode/issue logic and writeback.

---
 rtl/alu_pkg.sv | 33 +++
 rtl/alu_core.sv | 59 +++++
 rtl/alu_arbiter.sv | 135 +++++++++++++
 tb/tb_alu_arbiter.sv | 344 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared types for the two-requester ALU arbiter: op codes, flag layout and
// response-buffer states.
package alu_pkg;

  localparam int unsigned ALU_OPW     = 4;
  localparam int unsigned ALU_OP_LAST = 9;

  typedef enum logic [ALU_OPW-1:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_AND  = 4'd2,
    ALU_OR   = 4'd3,
    ALU_SLL  = 4'd4,
    ALU_SLTU = 4'd5,
    ALU_SLT  = 4'd6,
    ALU_XOR  = 4'd7,
    ALU_SRL  = 4'd8,
    ALU_SRA  = 4'd9
  } alu_op_e;

  typedef struct packed {
    logic zero;
    logic negative;
    logic carry;
    logic overflow;
  } alu_flags_t;

  typedef enum logic {
    BUF_EMPTY = 1'b0,
    BUF_FULL  = 1'b1
  } buf_state_e;

endpackage

// File: rtl/alu_core.sv
// Purely combinational integer ALU: result, {zero, negative, carry, overflow}
// and an illegal-op indication (which forces result and flags to zero).
module alu_core
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned OPW   = 4
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [OPW-1:0]   op,
  output logic [WIDTH-1:0] result,
  output logic [3:0]       flags,
  output logic             illegal
);

  localparam int unsigned SHW = 5;

  logic             is_sub;
  logic [WIDTH-1:0] b_eff;
  logic [WIDTH:0]   sum;
  logic [SHW-1:0]   shamt;
  alu_flags_t       fl;

  // SUB shares the adder as a + ~b + 1 so carry/overflow come out uniformly
  assign is_sub = (op == OPW'(ALU_SUB));
  assign b_eff  = is_sub ? ~b : b;
  assign sum    = {1'b0, a} + {1'b0, b_eff} + (WIDTH+1)'(is_sub);
  assign shamt  = b[SHW-1:0];

  always_comb begin
    result  = '0;
    illegal = 1'b0;
    fl      = '0;
    case (op)
      OPW'(ALU_ADD), OPW'(ALU_SUB): begin
        result      = sum[WIDTH-1:0];
        fl.carry    = sum[WIDTH];
        fl.overflow = (a[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
      end
      OPW'(ALU_AND):  result = a & b;
      OPW'(ALU_OR):   result = a | b;
      OPW'(ALU_XOR):  result = a ^ b;
      OPW'(ALU_SLL):  result = a << shamt;
      OPW'(ALU_SRL):  result = a >> shamt;
      OPW'(ALU_SRA):  result = WIDTH'($signed(a) >>> shamt);
      OPW'(ALU_SLTU): result = WIDTH'(a < b);
      OPW'(ALU_SLT):  result = WIDTH'($signed(a) < $signed(b));
      default:        illegal = 1'b1;
    endcase
    if (!illegal) begin
      fl.zero     = (result == '0);
      fl.negative = result[WIDTH-1];
    end
  end

  assign flags = fl;

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one ALU between two requesters, with a
// single-entry registered response buffer tagged by requester ID.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned OPW   = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       req_valid,
  output logic [1:0]       req_ready,
  input  logic [WIDTH-1:0] req_a0,
  input  logic [WIDTH-1:0] req_b0,
  input  logic [OPW-1:0]   req_op0,
  input  logic [WIDTH-1:0] req_a1,
  input  logic [WIDTH-1:0] req_b1,
  input  logic [OPW-1:0]   req_op1,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_result,
  output logic [3:0]       rsp_flags,
  output logic             rsp_illegal,
  output logic [15:0]      busy_cycles
);

  localparam int unsigned BUSYW = 16;
  localparam int unsigned FLAGW = 4;

  buf_state_e       state_q, state_d;
  logic             last_grant_q;
  logic [1:0]       grant;
  logic             can_accept;
  logic             accept;
  logic             sel;
  logic [WIDTH-1:0] op_a, op_b;
  logic [OPW-1:0]   op_code;
  logic [WIDTH-1:0] alu_result;
  logic [FLAGW-1:0] alu_flags;
  logic             alu_illegal;
  logic [WIDTH-1:0] result_q;
  logic [FLAGW-1:0] flags_q;
  logic             illegal_q;
  logic             id_q;
  logic [BUSYW-1:0] busy_q;

  // Buffer FSM: state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= BUF_EMPTY;
    else     state_q <= state_d;
  end

  // Buffer FSM: next state (an accept while FULL replaces the entry in place)
  always_comb begin
    state_d = state_q;
    case (state_q)
      BUF_EMPTY: if (accept) state_d = BUF_FULL;
      BUF_FULL:  if (rsp_ready && !accept) state_d = BUF_EMPTY;
      default:   state_d = BUF_EMPTY;
    endcase
  end

  // Buffer FSM: outputs
  always_comb begin
    rsp_valid = 1'b0;
    case (state_q)
      BUF_FULL: rsp_valid = 1'b1;
      default:  rsp_valid = 1'b0;
    endcase
  end

  assign can_accept = !rsp_valid || rsp_ready;

  // Round-robin: on contention the requester that did not win last time goes
  always_comb begin
    grant = 2'b00;
    case (req_valid)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = last_grant_q ? 2'b01 : 2'b10;
      default: grant = 2'b00;
    endcase
  end

  assign req_ready = (rst || !can_accept) ? 2'b00 : grant;
  assign accept    = |(req_valid & req_ready);
  assign sel       = req_ready[1];

  assign op_a    = sel ? req_a1  : req_a0;
  assign op_b    = sel ? req_b1  : req_b0;
  assign op_code = sel ? req_op1 : req_op0;

  alu_core #(
    .WIDTH (WIDTH),
    .OPW   (OPW)
  ) u_alu_core (
    .a       (op_a),
    .b       (op_b),
    .op      (op_code),
    .result  (alu_result),
    .flags   (alu_flags),
    .illegal (alu_illegal)
  );

  // Response payload and arbitration history update only on an accept
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      result_q     <= '0;
      flags_q      <= '0;
      illegal_q    <= 1'b0;
      id_q         <= 1'b0;
      last_grant_q <= 1'b1;
    end else if (accept) begin
      result_q     <= alu_result;
      flags_q      <= alu_flags;
      illegal_q    <= alu_illegal;
      id_q         <= sel;
      last_grant_q <= sel;
    end
  end

  // Saturating stall counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                           busy_q <= '0;
    else if (rsp_valid && !rsp_ready && busy_q != '1) busy_q <= busy_q + BUSYW'(1);
  end

  assign rsp_id      = id_q;
  assign rsp_result  = result_q;
  assign rsp_flags   = flags_q;
  assign rsp_illegal = illegal_q;
  assign busy_cycles = busy_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: directed scenarios plus randomized
// traffic compared against a transaction-level reference model.
module tb_alu_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [31:0] req_a0, req_b0, req_a1, req_b1;
  logic [3:0]  req_op0, req_op1;
  logic        rsp_valid, rsp_ready, rsp_id, rsp_illegal;
  logic [31:0] rsp_result;
  logic [3:0]  rsp_flags;
  logic [15:0] busy_cycles;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  logic        m_valid, m_id, m_last, m_illegal;
  logic [31:0] m_result;
  logic [3:0]  m_flags;
  int          m_busy;

  alu_arbiter #(.WIDTH(32), .OPW(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_a0      (req_a0),
    .req_b0      (req_b0),
    .req_op0     (req_op0),
    .req_a1      (req_a1),
    .req_b1      (req_b1),
    .req_op1     (req_op1),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_id      (rsp_id),
    .rsp_result  (rsp_result),
    .rsp_flags   (rsp_flags),
    .rsp_illegal (rsp_illegal),
    .busy_cycles (busy_cycles)
  );

  always #5 clk = ~clk;

  // Arithmetic reference: overflow is detected by comparing the exact 64-bit
  // result with the sign-extended 32-bit one.
  function automatic void ref_alu(input logic [31:0] a, input logic [31:0] b, input logic [3:0] op,
                                  output logic [31:0] r, output logic [3:0] f, output logic il);
    longint          sa, sb, s;
    longint unsigned ua, ub;
    logic            c, v;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'b0, a};
    ub = {32'b0, b};
    c = 1'b0; v = 1'b0; il = 1'b0; r = 32'b0;
    case (op)
      4'd0: begin r = a + b; c = (ua + ub) > 64'hFFFF_FFFF; s = sa + sb; v = (s != longint'($signed(r))); end
      4'd1: begin r = a - b; c = (a >= b); s = sa - sb; v = (s != longint'($signed(r))); end
      4'd2: r = a & b;
      4'd3: r = a | b;
      4'd4: r = a << b[4:0];
      4'd5: r = (a < b) ? 32'd1 : 32'd0;
      4'd6: r = (sa < sb) ? 32'd1 : 32'd0;
      4'd7: r = a ^ b;
      4'd8: r = a >> b[4:0];
      4'd9: r = 32'(sa >>> b[4:0]);
      default: il = 1'b1;
    endcase
    f = il ? 4'b0 : {r == 32'b0, r[31], c, v};
  endfunction

  function automatic logic [1:0] model_ready();
    if (rst || (m_valid && !rsp_ready)) return 2'b00;
    if (req_valid == 2'b11) return m_last ? 2'b01 : 2'b10;
    return req_valid;
  endfunction

  task automatic model_reset();
    m_valid = 1'b0; m_id = 1'b0; m_last = 1'b1; m_illegal = 1'b0;
    m_result = 32'b0; m_flags = 4'b0; m_busy = 0;
  endtask

  // Advance one clock, updating the model from the inputs held across the edge
  task automatic cycle();
    logic [1:0]  rdy;
    logic [31:0] r;
    logic [3:0]  f;
    logic        il;
    rdy = model_ready();
    if (m_valid && !rsp_ready && m_busy < 65535) m_busy++;
    if (|(req_valid & rdy)) begin
      if (rdy[1]) ref_alu(req_a1, req_b1, req_op1, r, f, il);
      else        ref_alu(req_a0, req_b0, req_op0, r, f, il);
      m_valid = 1'b1; m_id = rdy[1]; m_last = rdy[1];
      m_result = r; m_flags = f; m_illegal = il;
    end else if (rsp_ready) begin
      m_valid = 1'b0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; req_valid = 2'b00; rsp_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    model_reset();
  endtask

  task automatic drain();
    req_valid = 2'b00; rsp_ready = 1'b1;
    cycle();
  endtask

  task automatic test_reset();
    rst = 1'b1; req_valid = 2'b11; rsp_ready = 1'b1;
    req_a0 = 32'd0; req_b0 = 32'd0; req_op0 = 4'd0;
    req_a1 = 32'd0; req_b1 = 32'd0; req_op1 = 4'd0;
    #3;
    n_checks++;
    if ({rsp_valid, rsp_id, rsp_result, rsp_flags, rsp_illegal, busy_cycles} !== 55'b0) begin
      n_fail++;
      $display("FAIL reset_outputs: got v=%b id=%b res=%h fl=%b il=%b busy=%0d, want all zero",
               rsp_valid, rsp_id, rsp_result, rsp_flags, rsp_illegal, busy_cycles);
    end
    n_checks++;
    if (req_ready !== 2'b00) begin
      n_fail++; $display("FAIL reset_ready: got %b want 00", req_ready);
    end
    @(posedge clk); #1 rst = 1'b0;
    model_reset();
    #1;
    n_checks++;
    if (req_ready !== 2'b01) begin
      n_fail++; $display("FAIL reset_first_grant: got %b want 01", req_ready);
    end
    req_valid = 2'b00;
  endtask

  task automatic test_add_single();
    req_a0 = 32'h7FFF_FFFF; req_b0 = 32'd1; req_op0 = 4'd0;
    req_valid = 2'b01; rsp_ready = 1'b1;
    #1;
    n_checks++;
    if (req_ready !== 2'b01) begin
      n_fail++; $display("FAIL add_ready: got %b want 01", req_ready);
    end
    cycle();
    req_valid = 2'b00;
    n_checks++;
    if ({rsp_valid, rsp_id, rsp_result, rsp_flags, rsp_illegal} !== {1'b1, 1'b0, 32'h8000_0000, 4'b0101, 1'b0}) begin
      n_fail++;
      $display("FAIL add_overflow: got v=%b id=%b res=%h fl=%b il=%b want v=1 id=0 res=80000000 fl=0101 il=0",
               rsp_valid, rsp_id, rsp_result, rsp_flags, rsp_illegal);
    end
    drain();
  endtask

  task automatic test_contention();
    logic exp_id;
    do_reset();
    req_a0 = 32'd5; req_b0 = 32'd5; req_op0 = 4'd1;
    req_a1 = 32'hFFFF_FFFF; req_b1 = 32'd1; req_op1 = 4'd6;
    req_valid = 2'b11; rsp_ready = 1'b1;
    #1;
    for (int i = 0; i < 4; i++) begin
      exp_id = 1'(i % 2);
      n_checks++;
      if (req_ready !== (exp_id ? 2'b10 : 2'b01)) begin
        n_fail++; $display("FAIL contention_ready[%0d]: got %b want one-hot %0d", i, req_ready, exp_id);
      end
      cycle();
      n_checks++;
      if ({rsp_valid, rsp_id, rsp_result, rsp_flags} !==
          (exp_id ? {1'b1, 1'b1, 32'd1, 4'b0000} : {1'b1, 1'b0, 32'd0, 4'b1010})) begin
        n_fail++;
        $display("FAIL contention_rsp[%0d]: got v=%b id=%b res=%h fl=%b want id=%0d",
                 i, rsp_valid, rsp_id, rsp_result, rsp_flags, exp_id);
      end
    end
    drain();
  endtask

  task automatic test_backpressure();
    do_reset();
    req_a0 = 32'h0000_F0F0; req_b0 = 32'h0000_0FF0; req_op0 = 4'd7;
    req_valid = 2'b01; rsp_ready = 1'b0;
    #1;
    cycle();
    req_a1 = 32'd3; req_b1 = 32'd4; req_op1 = 4'd0;
    req_valid = 2'b10;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_checks++;
      if (req_ready !== 2'b00) begin
        n_fail++; $display("FAIL bp_ready[%0d]: got %b want 00", i, req_ready);
      end
      cycle();
      n_checks++;
      if ({rsp_valid, rsp_id, rsp_result} !== {1'b1, 1'b0, 32'h0000_FF00}) begin
        n_fail++; $display("FAIL bp_hold[%0d]: got v=%b id=%b res=%h want v=1 id=0 res=0000ff00",
                           i, rsp_valid, rsp_id, rsp_result);
      end
    end
    n_checks++;
    if (busy_cycles !== 16'd3) begin
      n_fail++; $display("FAIL bp_busy: got %0d want 3", busy_cycles);
    end
    rsp_ready = 1'b1;
    #1;
    n_checks++;
    if (req_ready !== 2'b10) begin
      n_fail++; $display("FAIL bp_release_ready: got %b want 10", req_ready);
    end
    cycle();
    n_checks++;
    if ({rsp_valid, rsp_id, rsp_result, busy_cycles} !== {1'b1, 1'b1, 32'd7, 16'd3}) begin
      n_fail++; $display("FAIL bp_replace: got v=%b id=%b res=%h busy=%0d want v=1 id=1 res=7 busy=3",
                         rsp_valid, rsp_id, rsp_result, busy_cycles);
    end
    drain();
  endtask

  task automatic test_shifts();
    req_a0 = 32'h8000_0000; req_b0 = 32'h0000_0024; req_op0 = 4'd9;
    req_valid = 2'b01; rsp_ready = 1'b1;
    #1;
    cycle();
    n_checks++;
    if (rsp_result !== 32'hF800_0000) begin
      n_fail++; $display("FAIL sra: got %h want f8000000", rsp_result);
    end
    req_op0 = 4'd8;
    cycle();
    n_checks++;
    if (rsp_result !== 32'h0800_0000) begin
      n_fail++; $display("FAIL srl: got %h want 08000000", rsp_result);
    end
    drain();
  endtask

  task automatic test_illegal();
    req_a1 = $urandom(); req_b1 = $urandom(); req_op1 = 4'hC;
    req_valid = 2'b10; rsp_ready = 1'b1;
    #1;
    cycle();
    n_checks++;
    if ({rsp_valid, rsp_id, rsp_illegal, rsp_result, rsp_flags} !== {1'b1, 1'b1, 1'b1, 32'd0, 4'd0}) begin
      n_fail++; $display("FAIL illegal_op: got v=%b id=%b il=%b res=%h fl=%b want 1 1 1 0 0",
                         rsp_valid, rsp_id, rsp_illegal, rsp_result, rsp_flags);
    end
    drain();
  endtask

  task automatic test_reset_mid();
    req_a0 = 32'd10; req_b0 = 32'd20; req_op0 = 4'd0;
    req_a1 = 32'd1;  req_b1 = 32'd2;  req_op1 = 4'd3;
    req_valid = 2'b01; rsp_ready = 1'b0;
    #1;
    cycle();
    req_valid = 2'b11;
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if ({rsp_valid, req_ready, busy_cycles} !== 19'b0) begin
      n_fail++; $display("FAIL reset_mid: got v=%b ready=%b busy=%0d want all zero",
                         rsp_valid, req_ready, busy_cycles);
    end
    @(posedge clk); #2 rst = 1'b0;
    model_reset();
    #1;
    n_checks++;
    if (req_ready !== 2'b01) begin
      n_fail++; $display("FAIL reset_mid_grant: got %b want 01", req_ready);
    end
    cycle();
    n_checks++;
    if ({rsp_valid, rsp_id, rsp_result} !== {1'b1, 1'b0, 32'd30}) begin
      n_fail++; $display("FAIL reset_mid_rsp: got v=%b id=%b res=%h want v=1 id=0 res=1e",
                         rsp_valid, rsp_id, rsp_result);
    end
    drain();
  endtask

  task automatic test_random();
    logic [1:0] exp_rdy;
    do_reset();
    for (int n = 0; n < 400; n++) begin
      // Requesters hold a pending request until it is accepted
      if (!req_valid[0] && $urandom_range(0, 9) < 6) begin
        req_a0 = ($urandom_range(0, 3) == 0) ? 32'h8000_0000 : $urandom();
        req_b0 = ($urandom_range(0, 3) == 0) ? req_a0 : $urandom();
        req_op0 = 4'($urandom_range(0, 15));
        req_valid[0] = 1'b1;
      end
      if (!req_valid[1] && $urandom_range(0, 9) < 6) begin
        req_a1 = ($urandom_range(0, 3) == 0) ? 32'h7FFF_FFFF : $urandom();
        req_b1 = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : $urandom();
        req_op1 = 4'($urandom_range(0, 15));
        req_valid[1] = 1'b1;
      end
      rsp_ready = ($urandom_range(0, 3) != 0);
      #1;
      exp_rdy = model_ready();
      n_checks++;
      if (req_ready !== exp_rdy) begin
        n_fail++; $display("FAIL rnd_ready[%0d]: got %b want %b", n, req_ready, exp_rdy);
      end
      cycle();
      req_valid = req_valid & ~exp_rdy;
      n_checks++;
      if (rsp_valid !== m_valid || busy_cycles !== 16'(m_busy)) begin
        n_fail++; $display("FAIL rnd_state[%0d]: got v=%b busy=%0d want v=%b busy=%0d",
                           n, rsp_valid, busy_cycles, m_valid, m_busy);
      end
      if (m_valid) begin
        n_checks++;
        if ({rsp_id, rsp_result, rsp_flags, rsp_illegal} !== {m_id, m_result, m_flags, m_illegal}) begin
          n_fail++;
          $display("FAIL rnd_rsp[%0d]: got id=%b res=%h fl=%b il=%b want id=%b res=%h fl=%b il=%b",
                   n, rsp_id, rsp_result, rsp_flags, rsp_illegal, m_id, m_result, m_flags, m_illegal);
        end
      end
    end
    drain();
  endtask

  initial begin
    test_reset();
    test_add_single();
    test_contention();
    test_backpressure();
    test_shifts();
    test_illegal();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
